// File: rtl/scaler_pkg.sv
// Shared types and constants for the pitch-scaler scheduler.
package scaler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        RUN,
        HANDOFF
    } sched_state_t;

    localparam int BIN_ADDR_W       = 12;
    localparam int NUM_BINS_DEFAULT = 4096;

    typedef logic buf_sel_t;

endpackage

// File: rtl/scaler_sched_if.sv
// Scheduler bus: cart_to_polar, scaler, buffer clear and polar_to_cart.
// SCALER_SCHED_STATS_EN adds the win/overrun counters.
interface scaler_sched_if
    import scaler_pkg::*;
#(
    parameter int ADDR_W = BIN_ADDR_W
);
    logic              c2p_done;
    buf_sel_t          c2p_win;
    logic [7:0]        shift_amt_in;
    logic              scl_go;
    buf_sel_t          scl_window;
    logic [7:0]        scl_shift_amt;
    logic              scl_done;
    logic              clr_buf;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_wren;
    logic              p2c_busy;
    logic              p2c_go;
    buf_sel_t          p2c_buf;
    logic              overrun;
    logic              busy;
`ifdef SCALER_SCHED_STATS_EN
    logic [15:0]       win_count;
    logic [15:0]       overrun_count;

    modport master (
        input  c2p_done, c2p_win, shift_amt_in,
        input  scl_done, p2c_busy,
        output scl_go, scl_window, scl_shift_amt,
        output clr_buf, clr_addr, clr_wren,
        output p2c_go, p2c_buf, overrun, busy,
        output win_count, overrun_count
    );

    modport slave (
        output c2p_done, c2p_win, shift_amt_in,
        output scl_done, p2c_busy,
        input  scl_go, scl_window, scl_shift_amt,
        input  clr_buf, clr_addr, clr_wren,
        input  p2c_go, p2c_buf, overrun, busy,
        input  win_count, overrun_count
    );
`else
    modport master (
        input  c2p_done, c2p_win, shift_amt_in,
        input  scl_done, p2c_busy,
        output scl_go, scl_window, scl_shift_amt,
        output clr_buf, clr_addr, clr_wren,
        output p2c_go, p2c_buf, overrun, busy
    );

    modport slave (
        output c2p_done, c2p_win, shift_amt_in,
        output scl_done, p2c_busy,
        input  scl_go, scl_window, scl_shift_amt,
        input  clr_buf, clr_addr, clr_wren,
        input  p2c_go, p2c_buf, overrun, busy
    );
`endif

endinterface

// File: rtl/scaler_sched_buf_clear_ctr.sv
// Ascending clear-address counter: one write per cycle, 0..NUM_BINS-1.
module buf_clear_ctr #(
    parameter int ADDR_W   = 12,
    parameter int NUM_BINS = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wren_o,
    output logic              last_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BINS - 1);

    logic              active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        active_d = active_q;
        addr_d   = addr_q;
        if (start_i) begin
            active_d = 1'b1;
            addr_d   = '0;
        end else if (active_q) begin
            if (addr_q == LAST) begin
                active_d = 1'b0;
                addr_d   = '0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign wren_o = active_q;
    assign last_o = active_q && (addr_q == LAST);

endmodule

// File: rtl/scaler_sched.sv
// Schedules the pitch scaler over the ping-pong window buffers.
// SCALER_SCHED_STATS_EN adds saturating win/overrun counters.
module scaler_sched
    import scaler_pkg::*;
#(
    parameter int ADDR_W   = BIN_ADDR_W,
    parameter int NUM_BINS = NUM_BINS_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    scaler_sched_if.master bus
);
    sched_state_t state_q, state_d;
    buf_sel_t     win_q, win_d;
    buf_sel_t     last_win_q, last_win_d;
    buf_sel_t     p2c_buf_q, p2c_buf_d;
    buf_sel_t     pick;
    logic [7:0]   shift_q, shift_d;
    logic [1:0]   pend_q, pend_d;
    logic         rearm_q, rearm_d;
    logic         overrun_q, overrun_d;
    logic         done_q;
    logic         done_edge, hit_active, dup;
    logic         clr_start, clr_last;
    logic         scl_go, p2c_go, pend_clr;

    assign done_edge  = bus.scl_done && !done_q && (state_q == RUN);
    assign hit_active = bus.c2p_done && (state_q != IDLE)
                        && (bus.c2p_win == win_q);
    assign dup        = bus.c2p_done && pend_q[bus.c2p_win];

    always_comb begin
        pick = ~last_win_q;
        unique case (1'b1)
            pend_q == 2'b01: pick = 1'b0;
            pend_q == 2'b10: pick = 1'b1;
            default:         pick = ~last_win_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        shift_d    = shift_q;
        last_win_d = last_win_q;
        p2c_buf_d  = p2c_buf_q;
        rearm_d    = rearm_q | hit_active;
        clr_start  = 1'b0;
        scl_go     = 1'b0;
        p2c_go     = 1'b0;
        pend_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_q != 2'b00) begin
                    win_d     = pick;
                    shift_d   = bus.shift_amt_in;
                    clr_start = 1'b1;
                    rearm_d   = 1'b0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_last) state_d = START;
            end
            START: begin
                scl_go  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                // A re-request of the active window keeps it pending.
                if (done_edge) begin
                    pend_clr   = !(rearm_q || hit_active);
                    last_win_d = win_q;
                    state_d    = HANDOFF;
                end
            end
            HANDOFF: begin
                if (!bus.p2c_busy) begin
                    p2c_go    = 1'b1;
                    p2c_buf_d = win_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pend_d = pend_q;
        if (pend_clr) pend_d[win_q] = 1'b0;
        if (bus.c2p_done) pend_d[bus.c2p_win] = 1'b1;
        overrun_d = dup || hit_active;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            win_q      <= 1'b0;
            last_win_q <= 1'b1;
            p2c_buf_q  <= 1'b0;
            shift_q    <= '0;
            pend_q     <= '0;
            rearm_q    <= 1'b0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            last_win_q <= last_win_d;
            p2c_buf_q  <= p2c_buf_d;
            shift_q    <= shift_d;
            pend_q     <= pend_d;
            rearm_q    <= rearm_d;
            overrun_q  <= overrun_d;
            done_q     <= bus.scl_done;
        end
    end

    buf_clear_ctr #(
        .ADDR_W   (ADDR_W),
        .NUM_BINS (NUM_BINS)
    ) u_clr (
        .clk     (clk),
        .reset   (reset),
        .start_i (clr_start),
        .addr_o  (bus.clr_addr),
        .wren_o  (bus.clr_wren),
        .last_o  (clr_last)
    );

    assign bus.scl_go        = scl_go;
    assign bus.scl_window    = win_q;
    assign bus.scl_shift_amt = shift_q;
    assign bus.clr_buf       = win_q;
    assign bus.p2c_go        = p2c_go;
    assign bus.p2c_buf       = p2c_go ? win_q : p2c_buf_q;
    assign bus.overrun       = overrun_q;
    assign bus.busy          = (state_q != IDLE);

`ifdef SCALER_SCHED_STATS_EN
    logic [15:0] win_cnt_q, ovr_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt_q <= '0;
            ovr_cnt_q <= '0;
        end else begin
            if (p2c_go && (win_cnt_q != 16'hFFFF))
                win_cnt_q <= win_cnt_q + 16'd1;
            if (overrun_q && (ovr_cnt_q != 16'hFFFF))
                ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end
    end

    assign bus.win_count     = win_cnt_q;
    assign bus.overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_scaler_sched.sv
// Bench for scaler_sched: directed scenarios plus randomized single windows.
module tb_scaler_sched;
    localparam int N  = 8;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scaler_sched_if #(.ADDR_W(AW)) bus ();

    scaler_sched #(
        .ADDR_W   (AW),
        .NUM_BINS (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {int cyc; int addr; int bsel;} clr_rec_t;
    typedef struct {int cyc; int win; int shift;} ev_rec_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int run_len = 5;
    int run_cnt = 0;
    int ovr_cnt = 0;
    clr_rec_t clr_q[$];
    ev_rec_t  go_q[$];
    ev_rec_t  p2c_q[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bus.clr_wren === 1'b1)
            clr_q.push_back('{cyc, int'(bus.clr_addr), int'(bus.clr_buf)});
        if (bus.scl_go === 1'b1)
            go_q.push_back('{cyc, int'(bus.scl_window), int'(bus.scl_shift_amt)});
        if (bus.p2c_go === 1'b1)
            p2c_q.push_back('{cyc, int'(bus.p2c_buf), int'(bus.scl_shift_amt)});
        if (bus.overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
    end

    // Scaler stand-in: done drops on go, rises run_len cycles later and stays high.
    always @(negedge clk) begin
        if (reset) begin
            bus.scl_done = 1'b0;
            run_cnt = 0;
        end else if (bus.scl_go === 1'b1) begin
            bus.scl_done = 1'b0;
            run_cnt = run_len;
        end else if (run_cnt > 0) begin
            run_cnt = run_cnt - 1;
            if (run_cnt == 0) bus.scl_done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int w, output int c);
        step();
        bus.c2p_done = 1'b1;
        bus.c2p_win  = 1'(w);
        c = cyc;
        step();
        bus.c2p_done = 1'b0;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        bus.p2c_busy = 1'b0;
        bus.c2p_done = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int quiet = 0;
        ok = 1'b0;
        repeat (2) step();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        do_reset();
        @(negedge clk);
        flags = {bus.scl_go, bus.scl_window, bus.clr_wren, bus.clr_buf,
                 bus.p2c_go, bus.p2c_buf, bus.overrun, bus.busy};
        tests++;
        if (flags !== 8'h00) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00000000", flags);
        end
        tests++;
        if (bus.scl_shift_amt !== 8'h00) begin
            fails++;
            $display("FAIL reset_shift: got %h want 00", bus.scl_shift_amt);
        end
        tests++;
        if (bus.clr_addr !== '0) begin
            fails++;
            $display("FAIL reset_addr: got %0d want 0", bus.clr_addr);
        end
`ifdef SCALER_SCHED_STATS_EN
        tests++;
        if ({bus.win_count, bus.overrun_count} !== 32'h0) begin
            fails++;
            $display("FAIL reset_stats: got %h/%h want 0/0",
                     bus.win_count, bus.overrun_count);
        end
`endif
    endtask

    task automatic test_single();
        int c, s_clr, s_go, s_p2c, s_ovr;
        bit ok;
        do_reset();
        run_len = 20;
        bus.shift_amt_in = 8'h40;
        s_clr = clr_q.size(); s_go = go_q.size();
        s_p2c = p2c_q.size(); s_ovr = ovr_cnt;
        pulse(0, c);
        wait_idle(300, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL single_timeout: busy stuck"); end
        tests++;
        if (clr_q.size() - s_clr != N) begin
            fails++;
            $display("FAIL single_clr_cnt: got %0d want %0d", clr_q.size() - s_clr, N);
        end else begin
            for (int i = 0; i < N; i++) begin
                tests++;
                if (clr_q[s_clr+i].addr != i || clr_q[s_clr+i].bsel != 0
                    || clr_q[s_clr+i].cyc != c + 2 + i) begin
                    fails++;
                    $display("FAIL single_clr_%0d: got a=%0d b=%0d t=%0d want a=%0d b=0 t=%0d",
                             i, clr_q[s_clr+i].addr, clr_q[s_clr+i].bsel,
                             clr_q[s_clr+i].cyc, i, c + 2 + i);
                end
            end
        end
        tests++;
        if (go_q.size() - s_go != 1 || go_q[s_go].win != 0
            || go_q[s_go].shift != 'h40 || go_q[s_go].cyc != c + N + 2) begin
            fails++;
            $display("FAIL single_go: got n=%0d w=%0d s=%h t=%0d want n=1 w=0 s=40 t=%0d",
                     go_q.size() - s_go, go_q[s_go].win, go_q[s_go].shift,
                     go_q[s_go].cyc, c + N + 2);
        end
        tests++;
        if (p2c_q.size() - s_p2c != 1 || p2c_q[s_p2c].win != 0
            || p2c_q[s_p2c].cyc != c + N + 3 + 20) begin
            fails++;
            $display("FAIL single_p2c: got n=%0d b=%0d t=%0d want n=1 b=0 t=%0d",
                     p2c_q.size() - s_p2c, p2c_q[s_p2c].win,
                     p2c_q[s_p2c].cyc, c + N + 23);
        end
        tests++;
        if (ovr_cnt != s_ovr) begin
            fails++;
            $display("FAIL single_ovr: got %0d want 0", ovr_cnt - s_ovr);
        end
    endtask

    task automatic test_ping_pong();
        int c0, c1, s_go, s_p2c, s_ovr, h1;
        bit ok;
        do_reset();
        run_len = 6;
        s_go = go_q.size(); s_p2c = p2c_q.size(); s_ovr = ovr_cnt;
        pulse(0, c0);
        pulse(1, c1);
        wait_idle(300, ok);
        h1 = c0 + N + 3 + 6;
        tests++;
        if (!ok || p2c_q.size() - s_p2c != 2) begin
            fails++;
            $display("FAIL pp_count: got ok=%0d n=%0d want ok=1 n=2", ok, p2c_q.size() - s_p2c);
        end else begin
            tests++;
            if (p2c_q[s_p2c].win != 0 || p2c_q[s_p2c+1].win != 1) begin
                fails++;
                $display("FAIL pp_order: got %0d,%0d want 0,1",
                         p2c_q[s_p2c].win, p2c_q[s_p2c+1].win);
            end
            tests++;
            if (p2c_q[s_p2c].cyc != h1 || p2c_q[s_p2c+1].cyc != h1 + N + 3 + 6) begin
                fails++;
                $display("FAIL pp_timing: got %0d,%0d want %0d,%0d", p2c_q[s_p2c].cyc,
                         p2c_q[s_p2c+1].cyc, h1, h1 + N + 9);
            end
        end
        tests++;
        if (go_q.size() - s_go != 2 || go_q[s_go].win != 0 || go_q[s_go+1].win != 1) begin
            fails++;
            $display("FAIL pp_go: got n=%0d want n=2 order 0,1", go_q.size() - s_go);
        end
        tests++;
        if (ovr_cnt != s_ovr) begin
            fails++;
            $display("FAIL pp_ovr: got %0d want 0", ovr_cnt - s_ovr);
        end
    endtask

    task automatic test_tie_break();
        int c, c1, c2, h, s_clr, s_p2c, s_ovr;
        bit ok;
        do_reset();
        run_len = 4;
        bus.p2c_busy = 1'b1;
        s_clr = clr_q.size(); s_p2c = p2c_q.size(); s_ovr = ovr_cnt;
        pulse(0, c);
        h = c + N + 3 + 4;
        while (cyc < h + 1) step();
        pulse(1, c1);
        pulse(0, c2);
        step();
        bus.p2c_busy = 1'b0;
        wait_idle(400, ok);
        tests++;
        if (!ok || p2c_q.size() - s_p2c != 3) begin
            fails++;
            $display("FAIL tie_count: got ok=%0d n=%0d want ok=1 n=3", ok, p2c_q.size() - s_p2c);
        end else begin
            tests++;
            if (p2c_q[s_p2c].win != 0 || p2c_q[s_p2c+1].win != 1 || p2c_q[s_p2c+2].win != 0) begin
                fails++;
                $display("FAIL tie_order: got %0d,%0d,%0d want 0,1,0", p2c_q[s_p2c].win,
                         p2c_q[s_p2c+1].win, p2c_q[s_p2c+2].win);
            end
        end
        tests++;
        if (clr_q.size() - s_clr != 3 * N || clr_q[s_clr+N].bsel != 1) begin
            fails++;
            $display("FAIL tie_clr: got n=%0d b=%0d want n=%0d b=1",
                     clr_q.size() - s_clr, clr_q[s_clr+N].bsel, 3 * N);
        end
        tests++;
        if (ovr_cnt - s_ovr != 1) begin
            fails++;
            $display("FAIL tie_ovr: got %0d want 1", ovr_cnt - s_ovr);
        end
    endtask

    task automatic test_overrun();
        int c, c1, s_go, s_p2c, s_ovr;
        bit ok;
        do_reset();
        run_len = 20;
        s_go = go_q.size(); s_p2c = p2c_q.size(); s_ovr = ovr_cnt;
        pulse(0, c);
        while (cyc < c + N + 3 + 5) step();
        pulse(0, c1);
        wait_idle(400, ok);
        tests++;
        if (ovr_cnt - s_ovr != 1) begin
            fails++;
            $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt - s_ovr);
        end
        tests++;
        if (!ok || p2c_q.size() - s_p2c != 2 || go_q.size() - s_go != 2
            || p2c_q[s_p2c].win != 0 || p2c_q[s_p2c+1].win != 0) begin
            fails++;
            $display("FAIL ovr_reserve: got ok=%0d p2c=%0d go=%0d want ok=1 p2c=2 go=2 bufs 0,0",
                     ok, p2c_q.size() - s_p2c, go_q.size() - s_go);
        end
`ifdef SCALER_SCHED_STATS_EN
        tests++;
        if (bus.overrun_count !== 16'd1 || bus.win_count !== 16'd2) begin
            fails++;
            $display("FAIL ovr_stats: got ovr=%0d win=%0d want 1/2",
                     bus.overrun_count, bus.win_count);
        end
`endif
    endtask

    task automatic test_backpressure_reset();
        int c, h, s_clr, s_go, s_p2c;
        bit ok;
        do_reset();
        run_len = 5;
        bus.p2c_busy = 1'b1;
        s_p2c = p2c_q.size();
        pulse(0, c);
        h = c + N + 3 + 5;
        while (cyc < h + 10) begin
            step();
            if (cyc == h + 5) begin
                tests++;
                if (bus.busy !== 1'b1 || bus.p2c_go !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_hold: got busy=%b go=%b want 1/0", bus.busy, bus.p2c_go);
                end
            end
        end
        bus.p2c_busy = 1'b0;
        wait_idle(100, ok);
        tests++;
        if (!ok || p2c_q.size() - s_p2c != 1 || p2c_q[s_p2c].cyc != h + 10
            || p2c_q[s_p2c].win != 0) begin
            fails++;
            $display("FAIL bp_release: got n=%0d t=%0d b=%0d want n=1 t=%0d b=0",
                     p2c_q.size() - s_p2c, p2c_q[s_p2c].cyc, p2c_q[s_p2c].win, h + 10);
        end
        pulse(1, c);
        while (cyc < c + 5) step();
        tests++;
        if (bus.clr_wren !== 1'b1 || bus.clr_addr !== AW'(3)) begin
            fails++;
            $display("FAIL rst_mid_pre: got wren=%b addr=%0d want 1/3", bus.clr_wren, bus.clr_addr);
        end
        reset = 1'b1;
        step();
        tests++;
        if (bus.clr_wren !== 1'b0 || bus.busy !== 1'b0 || bus.scl_go !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_abort: got wren=%b busy=%b go=%b want 0/0/0",
                     bus.clr_wren, bus.busy, bus.scl_go);
        end
        reset = 1'b0;
        s_clr = clr_q.size(); s_go = go_q.size(); s_p2c = p2c_q.size();
        repeat (40) step();
        tests++;
        if (clr_q.size() != s_clr || go_q.size() != s_go
            || p2c_q.size() != s_p2c || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_quiet: got clr=%0d go=%0d p2c=%0d busy=%b want 0/0/0/0",
                     clr_q.size() - s_clr, go_q.size() - s_go, p2c_q.size() - s_p2c, bus.busy);
        end
    endtask

    task automatic test_shift_latch();
        int c, c1, s_go, s_p2c;
        bit ok;
        do_reset();
        run_len = 5;
        bus.shift_amt_in = 8'h40;
        s_go = go_q.size(); s_p2c = p2c_q.size();
        pulse(0, c);
        step();
        bus.shift_amt_in = 8'h20;
        pulse(1, c1);
        wait_idle(300, ok);
        tests++;
        if (!ok || go_q.size() - s_go != 2 || go_q[s_go].shift != 'h40
            || go_q[s_go+1].shift != 'h20) begin
            fails++;
            $display("FAIL shift_go: got n=%0d s=%h,%h want n=2 s=40,20",
                     go_q.size() - s_go, go_q[s_go].shift, go_q[s_go+1].shift);
        end
        tests++;
        if (p2c_q.size() - s_p2c != 2 || p2c_q[s_p2c].shift != 'h40
            || p2c_q[s_p2c+1].shift != 'h20) begin
            fails++;
            $display("FAIL shift_hold: got n=%0d s=%h,%h want n=2 s=40,20",
                     p2c_q.size() - s_p2c, p2c_q[s_p2c].shift, p2c_q[s_p2c+1].shift);
        end
    endtask

    task automatic test_random();
        int c, w, sh, l, b, exp_t, s_clr, s_go, s_p2c, s_ovr;
        bit ok;
        for (int it = 0; it < 12; it++) begin
            w  = int'($urandom_range(0, 1));
            sh = int'($urandom_range(0, 255));
            l  = int'($urandom_range(1, 12));
            b  = int'($urandom_range(0, 4));
            run_len = l;
            bus.shift_amt_in = 8'(sh);
            bus.p2c_busy = (b > 0);
            s_clr = clr_q.size(); s_go = go_q.size();
            s_p2c = p2c_q.size(); s_ovr = ovr_cnt;
            pulse(w, c);
            step();
            bus.shift_amt_in = 8'(~sh);
            exp_t = c + N + 3 + l + b;
            while (cyc < exp_t) step();
            bus.p2c_busy = 1'b0;
            wait_idle(200, ok);
            tests++;
            if (!ok || go_q.size() - s_go != 1 || go_q[s_go].win != w
                || go_q[s_go].shift != sh) begin
                fails++;
                $display("FAIL rnd%0d_go: got n=%0d w=%0d s=%0d want n=1 w=%0d s=%0d", it,
                         go_q.size() - s_go, go_q[s_go].win, go_q[s_go].shift, w, sh);
            end
            tests++;
            if (p2c_q.size() - s_p2c != 1 || p2c_q[s_p2c].win != w
                || p2c_q[s_p2c].cyc != exp_t) begin
                fails++;
                $display("FAIL rnd%0d_p2c: got n=%0d b=%0d t=%0d want n=1 b=%0d t=%0d", it,
                         p2c_q.size() - s_p2c, p2c_q[s_p2c].win, p2c_q[s_p2c].cyc, w, exp_t);
            end
            tests++;
            if (clr_q.size() - s_clr != N || clr_q[s_clr].bsel != w
                || clr_q[s_clr+N-1].addr != N - 1 || ovr_cnt != s_ovr) begin
                fails++;
                $display("FAIL rnd%0d_clr: got n=%0d b=%0d ovr=%0d want n=%0d b=%0d ovr=0", it,
                         clr_q.size() - s_clr, clr_q[s_clr].bsel, ovr_cnt - s_ovr, N, w);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.c2p_done = 1'b0;
        bus.c2p_win = 1'b0;
        bus.shift_amt_in = 8'h00;
        bus.p2c_busy = 1'b0;
        test_reset();
        test_single();
        test_ping_pong();
        test_tie_break();
        test_overrun();
        test_backpressure_reset();
        test_shift_latch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/scaler_sched.md
Name: scaler_sched

Overview:
- Schedules the pitch scaler across the ping-pong window buffers.
- Accepts "window ready" pulses from cart_to_polar and queues up to two pending windows, oldest first.
- Before each run, zero-fills the selected post-scaler mag/phase buffer, which the scaler accumulates into. Then pulses the scaler's go_in, waits for its go_out, and hands the buffer to polar_to_cart.
- Latches shift_amt once per window so software changes never land mid-window.

Parameters:
- ADDR_W, 12, bin address width of the scaler buffers.
- NUM_BINS, 4096, bins per window; last clear address is NUM_BINS-1, NUM_BINS <= 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- c2p_done  in  1  one-cycle pulse from cart_to_polar: pre-scaler buffer c2p_win now full.
- c2p_win  in  1  buffer index qualified by c2p_done.
- shift_amt_in  in  8  pitch shift from software_interface.
- scl_go  out  1  one-cycle start pulse to scaler go_in.
- scl_window  out  1  window for scaler cur_window, held stable from scl_go until done.
- scl_shift_amt  out  8  latched shift to scaler shift_amt.
- scl_done  in  1  scaler go_out; a level that rises on completion.
- clr_buf  out  1  post-scaler buffer being zeroed.
- clr_addr  out  ADDR_W  clear write address.
- clr_wren  out  1  write enable; wrdata is 0 for both mag and phase.
- p2c_busy  in  1  polar_to_cart busy; no handoff while high.
- p2c_go  out  1  one-cycle pulse: post-scaler buffer p2c_buf ready.
- p2c_buf  out  1  buffer index, held until next p2c_go.
- overrun  out  1  one-cycle pulse when a window is dropped or overwritten.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; pend[1:0]=0; last_win=1, so window 0 is served first on a tie; state IDLE; scl_done edge register = 0.
- Reset mid-operation aborts everything immediately. No p2c_go is issued for the aborted window.
- scl_done rising edge is detected with a one-cycle delayed copy. Only a 0->1 transition counts as done, and only in RUN.

pend handling (every cycle, independent of state):
- c2p_done sets pend[c2p_win].
- If pend[c2p_win] was already 1, or c2p_win == active window while state != IDLE: pulse overrun. pend stays 1 and the pending window is not duplicated.

FSM:
- IDLE: if pend != 0, pick a window.
  - If exactly one bit is set, take it.
  - If both are set, take ~last_win.
  - Latch win, scl_window=win, scl_shift_amt=shift_amt_in, clr_buf=win, clr_addr=0. Go to CLEAR.
  - A c2p_done in the same cycle is counted but not selectable until the next cycle.
- CLEAR:
  - clr_wren=1 for exactly NUM_BINS consecutive cycles, addresses 0..NUM_BINS-1 ascending.
  - After writing address NUM_BINS-1: clr_wren=0, go to START. Clear latency is NUM_BINS cycles.
- START: scl_go=1 for exactly one cycle, then RUN.
- RUN:
  - On a scl_done rising edge: clear pend[win], set last_win=win, go to HANDOFF.
  - If the edge and a c2p_done for win arrive in the same cycle, the set wins: pend[win] stays 1 and overrun pulses.
- HANDOFF:
  - If p2c_busy=0: p2c_go=1 for one cycle, p2c_buf=win, go to IDLE.
  - Otherwise wait. No timeout.
- Minimum turnaround from leaving IDLE to p2c_go: NUM_BINS + 3 + scaler run time.
- shift_amt_in changes after the IDLE selection cycle affect only the next window.

Optional Feature:
- Macro: SCALER_SCHED_STATS_EN.
- Defined: adds outputs win_count[15:0] and overrun_count[15:0].
  - win_count increments on every p2c_go.
  - overrun_count increments on every overrun pulse.
  - Both saturate at 16'hFFFF and clear only on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package scaler_pkg: typedef enum logic [2:0] sched_state_t {IDLE, CLEAR, START, RUN, HANDOFF}; constants BIN_ADDR_W=12 and NUM_BINS_DEFAULT=4096; typedef logic buf_sel_t.
- One natural sub-module, buf_clear_ctr: an address counter with start, wren and last-address outputs, parameterised by ADDR_W and NUM_BINS. The FSM and pend logic stay in scaler_sched.

Test Plan (NUM_BINS=8 for speed):
- Single window: c2p_done with win=0, shift_amt_in=8'h40.
  - Response: clr_wren for 8 cycles at addr 0..7, buf 0; then scl_go for 1 cycle with scl_window=0 and scl_shift_amt=8'h40.
  - Raise scl_done after 20 cycles: p2c_go 1 cycle later with p2c_buf=0.
- Ping-pong ordering: c2p_done win=0 then win=1 two cycles apart.
  - Response: window 0 is fully served, then window 1. Sequence of p2c_buf values is 0,1; no overrun.
- Tie-break: c2p_done win=1 and win=0 both pending before IDLE evaluates, last_win=0.
  - Response: window 1 is cleared first.
- Overrun: c2p_done win=0 during RUN on window 0.
  - Response: overrun pulses once; window 0 is served again after HANDOFF.
  - With SCALER_SCHED_STATS_EN: overrun_count=1 and win_count=2 at the end.
- Backpressure and reset: p2c_busy=1 when scl_done rises.
  - Response: p2c_go held off for 10 cycles; fires the cycle after p2c_busy drops.
  - Assert reset mid-CLEAR at addr 3: next cycle clr_wren=0, state IDLE, pend=0, no p2c_go.
- Shift latching: change shift_amt_in from 8'h40 to 8'h20 during CLEAR.
  - Response: scl_shift_amt remains 8'h40 for this window and reads 8'h20 for the next.
